// File: rtl/noc_seq_pkg.sv
// Shared op codes and FSM state encoding for the NoC phase sequencer,
// its routers and its traffic generators.
package noc_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP          = 3'd0,
    OP_INIT         = 3'd1,
    OP_LOAD_RT      = 3'd2,
    OP_LOAD_STAGING = 3'd3,
    OP_PHASE0       = 3'd4,
    OP_PHASE1       = 3'd5,
    OP_FILL         = 3'd6
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD_RT,
    S_FILL,
    S_LOAD_STAGING,
    S_PHASE0,
    S_PHASE1,
    S_DONE
  } state_e;

endpackage

// File: rtl/noc_cycle_counter.sv
// Saturating simulated-cycle counter with end-of-run compare.
// Ports: clk, rst, clear, incr, max_cycle in; count, last out.
module noc_cycle_counter #(
  parameter int CYCLE_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  incr,
  input  logic [CYCLE_BITS-1:0] max_cycle,
  output logic [CYCLE_BITS-1:0] count,
  output logic                  last
);

  logic [CYCLE_BITS:0] count_p1;

  // One bit wider so a saturated count still compares as >= any max.
  assign count_p1 = {1'b0, count} + 1'b1;
  assign last     = count_p1 >= {1'b0, max_cycle};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/noc_phase_sequencer.sv
// Sequences routers and traffic generators through init, routing-table
// load, fill and per-cycle staging/phase ops. Ports: clk, rst, start,
// max_cycle, rt_valid, traffic_pending, router_done in; router_op,
// router_en, rt_dst, traffic_op, traffic_en, in_cycle, busy, finished out.
module noc_phase_sequencer
  import noc_seq_pkg::*;
#(
  parameter int ROUTER_SIZE = 16,
  parameter int ROUTER_BITS = 4,
  parameter int CYCLE_BITS  = 16,
  parameter int OP_SIZE     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CYCLE_BITS-1:0]  max_cycle,
  input  logic [ROUTER_SIZE-1:0] rt_valid,
  input  logic [ROUTER_SIZE-1:0] traffic_pending,
  input  logic [ROUTER_SIZE-1:0] router_done,
  output logic [OP_SIZE-1:0]     router_op,
  output logic [ROUTER_SIZE-1:0] router_en,
  output logic [ROUTER_BITS-1:0] rt_dst,
  output logic [OP_SIZE-1:0]     traffic_op,
  output logic [ROUTER_SIZE-1:0] traffic_en,
  output logic [CYCLE_BITS-1:0]  in_cycle,
  output logic                   busy,
  output logic                   finished
);

  localparam logic [ROUTER_BITS-1:0] LAST_DST =
    ROUTER_BITS'(ROUTER_SIZE - 1);

  state_e state, next;
  op_e    rop, top;
  logic   clr;
  logic   inc;
  logic   last;

  noc_cycle_counter #(
    .CYCLE_BITS(CYCLE_BITS)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr),
    .incr     (inc),
    .max_cycle(max_cycle),
    .count    (in_cycle),
    .last     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  // rt_dst parks at the last router rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rt_dst <= '0;
    end else if (clr) begin
      rt_dst <= '0;
    end else if (state == S_LOAD_RT && rt_dst != LAST_DST) begin
      rt_dst <= rt_dst + 1'b1;
    end
  end

  always_comb begin
    next       = state;
    rop        = OP_NOP;
    top        = OP_NOP;
    router_en  = '0;
    traffic_en = '0;
    clr        = 1'b0;
    inc        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          next = S_INIT;
          clr  = 1'b1;
        end
      end
      S_INIT: begin
        rop        = OP_INIT;
        top        = OP_INIT;
        router_en  = '1;
        traffic_en = '1;
        clr        = 1'b1;
        next       = S_LOAD_RT;
      end
      S_LOAD_RT: begin
        rop       = OP_LOAD_RT;
        router_en = rt_valid;
        if (rt_dst == LAST_DST) begin
          next = S_FILL;
        end
      end
      S_FILL: begin
        top        = OP_FILL;
        traffic_en = traffic_pending;
        if (traffic_pending == '0) begin
          next = (max_cycle == '0) ? S_DONE : S_LOAD_STAGING;
        end
      end
      S_LOAD_STAGING: begin
        rop       = OP_LOAD_STAGING;
        router_en = '1;
        next      = S_PHASE0;
      end
      S_PHASE0: begin
        rop       = OP_PHASE0;
        router_en = '1;
        next      = S_PHASE1;
      end
      S_PHASE1: begin
        rop       = OP_PHASE1;
        router_en = '1;
        inc       = 1'b1;
        next      = (last || (&router_done)) ? S_DONE : S_LOAD_STAGING;
      end
      S_DONE: begin
        if (start) begin
          next = S_INIT;
          clr  = 1'b1;
        end
      end
      default: next = S_IDLE;
    endcase
  end

  assign router_op  = OP_SIZE'(rop);
  assign traffic_op = OP_SIZE'(top);
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign finished   = (state == S_DONE);

endmodule
